msrv32_pc_gen: RTL and testbench

//  Registered, parametrised program-counter generator for the msrv32 fetch stage.

---
 rtl/msrv32_pc_gen.sv | 137 +++++++++++++
 tb/tb_msrv32_pc_gen.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/msrv32_pc_gen.sv
// msrv32_pc_gen - program-counter generator for the msrv32 fetch stage.
//
// This block selects the next PC from one of five sources: boot, EPC, trap,
// branch target or the sequential step. The current PC is held in a register.
// After reset it runs a boot-wait sequence. A redirect that arrives while the
// instruction bus is stalled is latched, so it is not lost.
//
// Ports
//   msrv32_mp_clk_in            clock, rising edge
//   msrv32_mp_rst_n_in          asynchronous active-low reset
//   pc_src_in                   00 boot, 01 epc, 10 trap, 11 sequential/branch
//   epc_in                      mret return address
//   trap_address_in             trap vector address
//   branch_taken_in             branch/jump taken (only with pc_src_in=11)
//   iaddr_in                    branch target bits [XLEN-1:1]
//   instr_c_in                  current instruction is 16-bit (C_EXT only)
//   ahb_ready_in                instruction bus accepts the address this cycle
//   pc_out                      registered current PC
//   pc_plus_4_out               pc_out + 2 or 4
//   pc_mux_out                  combinational next-PC selection
//   i_addr_out                  address driven to the instruction bus
//   misaligned_instr_logic_out  taken-branch target misaligned
//   pc_valid_out                pc_out refers to a fetched instruction
//   redirect_pending_out        a latched redirect is waiting
module msrv32_pc_gen #(
   parameter int unsigned          XLEN         = 32,
   parameter logic [XLEN-1:0]      BOOT_ADDRESS = '0,
   parameter bit                   C_EXT        = 1'b0,
   parameter int unsigned          BOOT_WAIT    = 2
) (
   input  logic            msrv32_mp_clk_in,
   input  logic            msrv32_mp_rst_n_in,
   input  logic [1:0]      pc_src_in,
   input  logic [XLEN-1:0] epc_in,
   input  logic [XLEN-1:0] trap_address_in,
   input  logic            branch_taken_in,
   input  logic [XLEN-2:0] iaddr_in,
   input  logic            instr_c_in,
   input  logic            ahb_ready_in,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] pc_plus_4_out,
   output logic [XLEN-1:0] pc_mux_out,
   output logic [XLEN-1:0] i_addr_out,
   output logic            misaligned_instr_logic_out,
   output logic            pc_valid_out,
   output logic            redirect_pending_out
);

   localparam int unsigned CNT_W = (BOOT_WAIT > 1) ? $clog2(BOOT_WAIT) : 1;
   localparam logic [CNT_W-1:0] BOOT_LAST = (BOOT_WAIT == 0) ? '0 : CNT_W'(BOOT_WAIT - 1);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HOLD
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  boot_cnt;
   logic [XLEN-1:0]   redir_q;
   logic [XLEN-1:0]   target;
   logic [XLEN-1:0]   inc;
   logic [XLEN-1:0]   next_seq;
   logic              redirect;
   logic              misaligned;
   logic              boot_done;
   logic              accept;
   logic              latch_redir;

   // Next-PC datapath
   always_comb begin
      target   = {iaddr_in, 1'b0};
      inc      = (C_EXT && instr_c_in) ? XLEN'(2) : XLEN'(4);
      pc_plus_4_out = pc_out + inc;
      next_seq = branch_taken_in ? target : pc_plus_4_out;
      case (pc_src_in)
         2'b00:   pc_mux_out = BOOT_ADDRESS;
         2'b01:   pc_mux_out = epc_in;
         2'b10:   pc_mux_out = trap_address_in;
         default: pc_mux_out = next_seq;
      endcase
      redirect   = (pc_src_in != 2'b11) || branch_taken_in;
      misaligned = branch_taken_in && (pc_src_in == 2'b11) && target[1] && !C_EXT;
      misaligned_instr_logic_out = misaligned;
   end

   // With BOOT_WAIT=0 the counter is never compared, so leaving BOOT only needs ready.
   assign boot_done   = (BOOT_WAIT == 0) || (boot_cnt == BOOT_LAST);
   assign accept      = (state == ST_RUN) && ahb_ready_in && !misaligned;
   assign latch_redir = (state != ST_BOOT) && !ahb_ready_in && redirect && !misaligned;

   // State register
   always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
      if (!msrv32_mp_rst_n_in) state <= ST_BOOT;
      else                     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_BOOT: if (ahb_ready_in && boot_done) state_nxt = ST_RUN;
         ST_RUN:  if (latch_redir)               state_nxt = ST_HOLD;
         ST_HOLD: if (ahb_ready_in)              state_nxt = ST_RUN;
         default:                                state_nxt = ST_BOOT;
      endcase
   end

   // Output logic
   always_comb begin
      pc_valid_out         = (state != ST_BOOT);
      redirect_pending_out = (state == ST_HOLD);
      if (state == ST_BOOT) i_addr_out = BOOT_ADDRESS;
      else if (accept)      i_addr_out = pc_mux_out;
      else                  i_addr_out = pc_out;
   end

   // PC, boot counter and latched redirect
   always_ff @(posedge msrv32_mp_clk_in or negedge msrv32_mp_rst_n_in) begin
      if (!msrv32_mp_rst_n_in) begin
         pc_out   <= BOOT_ADDRESS;
         boot_cnt <= '0;
         redir_q  <= '0;
      end else begin
         if (state == ST_BOOT && !boot_done)
            boot_cnt <= boot_cnt + 1'b1;
         if (accept)
            pc_out <= pc_mux_out;
         else if (state == ST_HOLD && ahb_ready_in)
            pc_out <= redir_q;
         // In HOLD the latest redirect overwrites the earlier one while the bus is stalled.
         if (latch_redir)
            redir_q <= pc_mux_out;
      end
   end

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Directed bench for msrv32_pc_gen. Two instances share the same stimulus:
// one without compressed support and one with it (both BOOT_WAIT=2).
module tb_msrv32_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  pc_src = 2'b11;
   logic [31:0] epc = '0;
   logic [31:0] trap = '0;
   logic        br = 1'b0;
   logic [30:0] iaddr = '0;
   logic        instr_c = 1'b0;
   logic        ready = 1'b1;

   logic [31:0] pc0, pp0, mux0, ia0, pc1, pp1, mux1, ia1;
   logic        mis0, val0, pend0, mis1, val1, pend1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h0), .C_EXT(1'b0), .BOOT_WAIT(2)) dut0 (
      .msrv32_mp_clk_in(clk), .msrv32_mp_rst_n_in(rst_n), .pc_src_in(pc_src),
      .epc_in(epc), .trap_address_in(trap), .branch_taken_in(br), .iaddr_in(iaddr),
      .instr_c_in(instr_c), .ahb_ready_in(ready), .pc_out(pc0), .pc_plus_4_out(pp0),
      .pc_mux_out(mux0), .i_addr_out(ia0), .misaligned_instr_logic_out(mis0),
      .pc_valid_out(val0), .redirect_pending_out(pend0));

   msrv32_pc_gen #(.XLEN(32), .BOOT_ADDRESS(32'h0), .C_EXT(1'b1), .BOOT_WAIT(2)) dut1 (
      .msrv32_mp_clk_in(clk), .msrv32_mp_rst_n_in(rst_n), .pc_src_in(pc_src),
      .epc_in(epc), .trap_address_in(trap), .branch_taken_in(br), .iaddr_in(iaddr),
      .instr_c_in(instr_c), .ahb_ready_in(ready), .pc_out(pc1), .pc_plus_4_out(pp1),
      .pc_mux_out(mux1), .i_addr_out(ia1), .misaligned_instr_logic_out(mis1),
      .pc_valid_out(val1), .redirect_pending_out(pend1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Redirect both instances to addr via the EPC source (bus ready).
   task automatic load_pc(input logic [31:0] addr);
      pc_src = 2'b01; epc = addr; br = 1'b0; ready = 1'b1; instr_c = 1'b0;
      tick();
      pc_src = 2'b11;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc0, 32'h0); end
      checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", val0); end
      checks++; if (pend0 !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", pend0); end
      checks++; if (ia0 !== 32'h0) begin errors++; $display("FAIL reset_iaddr got %h exp 0", ia0); end
   endtask

   task automatic test_boot();
      pc_src = 2'b11; ready = 1'b1; br = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      #1;
      checks++; if (ia0 !== 32'h0 || val0 !== 1'b0) begin errors++; $display("FAIL boot_c0 got ia=%h v=%b exp ia=0 v=0", ia0, val0); end
      tick();
      checks++; if (ia0 !== 32'h0 || val0 !== 1'b0 || pc0 !== 32'h0) begin errors++; $display("FAIL boot_c1 got ia=%h v=%b pc=%h exp 0/0/0", ia0, val0, pc0); end
      tick();
      checks++; if (ia0 !== 32'h4 || val0 !== 1'b1 || pc0 !== 32'h0) begin errors++; $display("FAIL boot_run got ia=%h v=%b pc=%h exp 4/1/0", ia0, val0, pc0); end
      tick();
      checks++; if (pc0 !== 32'h4 || ia0 !== 32'h8) begin errors++; $display("FAIL seq_4 got pc=%h ia=%h exp 4/8", pc0, ia0); end
      tick();
      checks++; if (pc0 !== 32'h8 || ia0 !== 32'hC) begin errors++; $display("FAIL seq_8 got pc=%h ia=%h exp 8/c", pc0, ia0); end
   endtask

   task automatic test_branch();
      load_pc(32'h100);
      checks++; if (pc0 !== 32'h100) begin errors++; $display("FAIL epc_load got %h exp 100", pc0); end
      br = 1'b1; iaddr = 31'h40;
      #1;
      checks++; if (mux0 !== 32'h80 || ia0 !== 32'h80) begin errors++; $display("FAIL br_mux got mux=%h ia=%h exp 80", mux0, ia0); end
      tick();
      br = 1'b0;
      #1;
      checks++; if (pc0 !== 32'h80) begin errors++; $display("FAIL br_pc got %h exp 80", pc0); end
      checks++; if (pp0 !== 32'h84) begin errors++; $display("FAIL br_pp4 got %h exp 84", pp0); end
   endtask

   task automatic test_stall_redirect();
      load_pc(32'h200);
      ready = 1'b0; pc_src = 2'b10; trap = 32'h1C0;
      #1;
      checks++; if (ia0 !== 32'h200 || mux0 !== 32'h1C0) begin errors++; $display("FAIL stall_comb got ia=%h mux=%h exp 200/1c0", ia0, mux0); end
      tick();
      pc_src = 2'b11;
      #1;
      checks++; if (pc0 !== 32'h200 || pend0 !== 1'b1) begin errors++; $display("FAIL hold1 got pc=%h p=%b exp 200/1", pc0, pend0); end
      tick();
      checks++; if (pc0 !== 32'h200 || pend0 !== 1'b1 || ia0 !== 32'h200) begin errors++; $display("FAIL hold2 got pc=%h p=%b ia=%h exp 200/1/200", pc0, pend0, ia0); end
      ready = 1'b1;
      tick();
      checks++; if (pc0 !== 32'h1C0 || pend0 !== 1'b0) begin errors++; $display("FAIL hold_release got pc=%h p=%b exp 1c0/0", pc0, pend0); end
   endtask

   task automatic test_compressed();
      load_pc(32'h100);
      br = 1'b1; iaddr = 31'h81;
      #1;
      checks++; if (mis0 !== 1'b1 || ia0 !== 32'h100) begin errors++; $display("FAIL mis_c0 got mis=%b ia=%h exp 1/100", mis0, ia0); end
      checks++; if (mis1 !== 1'b0 || ia1 !== 32'h102) begin errors++; $display("FAIL mis_c1 got mis=%b ia=%h exp 0/102", mis1, ia1); end
      tick();
      br = 1'b0; instr_c = 1'b1;
      #1;
      checks++; if (pc0 !== 32'h100) begin errors++; $display("FAIL mis_hold got %h exp 100", pc0); end
      checks++; if (pc1 !== 32'h102) begin errors++; $display("FAIL c_target got %h exp 102", pc1); end
      checks++; if (pp1 !== 32'h104) begin errors++; $display("FAIL c_plus2 got %h exp 104", pp1); end
      checks++; if (pp0 !== 32'h104) begin errors++; $display("FAIL nc_plus4 got %h exp 104", pp0); end
      tick();
      instr_c = 1'b0;
      #1;
      checks++; if (pc1 !== 32'h104 || pc0 !== 32'h104) begin errors++; $display("FAIL c_step got pc1=%h pc0=%h exp 104/104", pc1, pc0); end
   endtask

   task automatic test_wrap();
      load_pc(32'hFFFF_FFFC);
      #1;
      checks++; if (pp0 !== 32'h0) begin errors++; $display("FAIL wrap_pp4 got %h exp 0", pp0); end
      tick();
      checks++; if (pc0 !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp 0", pc0); end
   endtask

   task automatic test_reset_in_hold();
      load_pc(32'h40);
      ready = 1'b0; pc_src = 2'b01; epc = 32'h300;
      tick();
      pc_src = 2'b11;
      checks++; if (pend0 !== 1'b1 || pc0 !== 32'h40) begin errors++; $display("FAIL pre_rst_hold got p=%b pc=%h exp 1/40", pend0, pc0); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (pc0 !== 32'h0 || pend0 !== 1'b0 || val0 !== 1'b0 || ia0 !== 32'h0) begin errors++; $display("FAIL rst_hold got pc=%h p=%b v=%b ia=%h exp 0/0/0/0", pc0, pend0, val0, ia0); end
      ready = 1'b1;
      @(negedge clk); rst_n = 1'b1;
      tick();
      checks++; if (val0 !== 1'b0 || pc0 !== 32'h0) begin errors++; $display("FAIL rst_boot got v=%b pc=%h exp 0/0", val0, pc0); end
      tick();
      checks++; if (val0 !== 1'b1 || pc0 !== 32'h0) begin errors++; $display("FAIL rst_run got v=%b pc=%h exp 1/0", val0, pc0); end
      tick();
      checks++; if (pc0 !== 32'h4) begin errors++; $display("FAIL rst_no_redir got %h exp 4", pc0); end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_branch();
      test_stall_redirect();
      test_compressed();
      test_wrap();
      test_reset_in_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
